debounce_4: RTL and testbench

DEBOUNCE_4 -- requirements
Module: debounce_4

---
 rtl/debounce_4_if.sv | 11 +
 rtl/debounce_4.sv | 55 +++++
 tb/tb_debounce_4.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/debounce_4_if.sv
// Debounce channel bundle: raw button levels in, debounced levels and edge pulses out.
// master drives btn_in (stimulus side); slave is the debouncer.
interface debounce_4_if;
   logic [3:0] btn_in;
   logic [3:0] data;
   logic [3:0] rise;
   logic [3:0] fall;

   modport master (output btn_in, input data, rise, fall);
   modport slave  (input btn_in, output data, rise, fall);
endinterface

// File: rtl/debounce_4.sv
// 4-channel switch debouncer with 2-flop sync; data settles 2+STABLE_CYCLES edges after a held level is first sampled.
// No backpressure: free-running, one rise/fall pulse per accepted change, all outputs registered.
module debounce_4 #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter logic [3:0]  RESET_VAL     = 4'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   debounce_4_if.slave bus
);
   localparam int          CW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    data_q;
   logic [3:0]    rise_q;
   logic [3:0]    fall_q;
   logic [CW-1:0] cnt [4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= RESET_VAL;
         sync2  <= RESET_VAL;
         data_q <= RESET_VAL;
         rise_q <= 4'h0;
         fall_q <= 4'h0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1  <= bus.btn_in;
         sync2  <= sync1;
         rise_q <= 4'h0;
         fall_q <= 4'h0;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == data_q[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
               // Level held long enough: accept it and restart the count.
               data_q[i] <= sync2[i];
               rise_q[i] <= sync2[i];
               fall_q[i] <= ~sync2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   assign bus.data = data_q;
   assign bus.rise = rise_q;
   assign bus.fall = fall_q;
endmodule

// File: tb/tb_debounce_4.sv
// Directed bench for debounce_4 with a sliding-window reference model checked every cycle.
module tb_debounce_4;
   localparam int         SC = 4;
   localparam logic [3:0] RV = 4'h0;

   logic clk;
   logic rst_n;
   int   errs;
   int   checks;

   debounce_4_if bus ();

   debounce_4 #(.STABLE_CYCLES(SC), .RESET_VAL(RV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a channel flips when the last SC synchronized samples all differ from it.
   // hist[j] is the btn_in sampled j+1 edges ago; the sync chain uses hist[1].
   logic [3:0] hist [0:SC];
   logic [3:0] m_data;
   logic [3:0] m_rise;
   logic [3:0] m_fall;

   always @(posedge clk or negedge rst_n) begin
      logic [3:0] nd;
      bit         all_diff;
      if (!rst_n) begin
         for (int j = 0; j <= SC; j++) hist[j] = RV;
         m_data = RV;
         m_rise = 4'h0;
         m_fall = 4'h0;
      end else begin
         nd = m_data;
         for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= SC; j++) begin
               if (hist[j][i] == m_data[i]) all_diff = 1'b0;
            end
            if (all_diff) nd[i] = hist[1][i];
         end
         m_rise = nd & ~m_data;
         m_fall = ~nd & m_data;
         m_data = nd;
         for (int j = SC; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = bus.btn_in;
      end
   end

   always @(negedge clk) begin
      check("model_data", bus.data, m_data);
      check("model_rise", bus.rise, m_rise);
      check("model_fall", bus.fall, m_fall);
      check("rise_fall_excl", bus.rise & bus.fall, 4'h0);
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      errs   = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.btn_in = 4'h0;
      @(negedge clk);
      check("reset_data", bus.data, RV);
      check("reset_rise", bus.rise, 4'h0);
      check("reset_fall", bus.fall, 4'h0);
      edges(1);
      rst_n = 1'b1;
      edges(2);
      check("leave_reset_rise", bus.rise, 4'h0);

      // Clean press on channel 0
      bus.btn_in = 4'h1;
      edges(5);
      check("press_before_edge6", bus.data, 4'h0);
      edges(1);
      check("press_data_edge6", bus.data, 4'h1);
      check("press_rise", bus.rise, 4'h1);
      edges(1);
      check("press_rise_once", bus.rise, 4'h0);
      bus.btn_in = 4'h0;
      edges(6);
      check("release_fall", bus.fall, 4'h1);
      check("release_data", bus.data, 4'h0);
      edges(2);

      // Glitch on channel 2: three clocks high
      bus.btn_in = 4'h4;
      edges(3);
      bus.btn_in = 4'h0;
      edges(10);
      check("glitch_data", bus.data, 4'h0);

      // Bounce on channel 1
      bus.btn_in = 4'h2; edges(2);
      bus.btn_in = 4'h0; edges(2);
      bus.btn_in = 4'h2; edges(2);
      bus.btn_in = 4'h0; edges(2);
      bus.btn_in = 4'h2;
      edges(5);
      check("bounce_before", bus.data, 4'h0);
      edges(1);
      check("bounce_data", bus.data, 4'h2);
      check("bounce_rise", bus.rise, 4'h2);
      bus.btn_in = 4'h0;
      edges(8);
      check("bounce_release", bus.data, 4'h0);

      // All channels, then the downstream AND combiner
      bus.btn_in = 4'hF;
      edges(6);
      check("all_data", bus.data, 4'hF);
      check("all_rise", bus.rise, 4'hF);
      edges(1);
      check("all_rise_once", bus.rise, 4'h0);
      check("and_high", {3'b000, &bus.data}, 4'h1);
      bus.btn_in = 4'h7;
      edges(6);
      check("and_low", {3'b000, &bus.data}, 4'h0);
      check("ch3_fall", bus.fall, 4'h8);
      bus.btn_in = 4'h0;
      edges(6);
      check("all_fall", bus.fall, 4'h7);
      check("all_released", bus.data, 4'h0);
      edges(2);

      // Reset mid-count
      bus.btn_in = 4'h8;
      edges(4);
      rst_n = 1'b0;
      #2;
      check("midreset_data", bus.data, 4'h0);
      check("midreset_rise", bus.rise, 4'h0);
      edges(2);
      rst_n = 1'b1;
      edges(5);
      check("postreset_before", bus.data, 4'h0);
      edges(1);
      check("postreset_data", bus.data, 4'h8);
      check("postreset_rise", bus.rise, 4'h8);
      edges(3);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
